// File: rtl/rv32i_if_stage.sv
// RV32I instruction-fetch stage: owns the PC, drives the ROM address and
// loads the IF/ID register with stall, flush and deferred-redirect handling.
module rv32i_if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  input  logic [31:0] inst_i,
  output logic        ce_o,
  output logic [31:0] pc_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        id_valid_o,
  output logic [31:0] fetch_cnt_o
);

  localparam int unsigned XLEN    = 32;
  localparam int unsigned ILEN_B  = 4;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              ce_nxt;
  logic [XLEN-1:0]   pc_nxt;
  logic              pend_valid;
  logic              pend_valid_nxt;
  logic [XLEN-1:0]   pend_pc;
  logic [XLEN-1:0]   pend_pc_nxt;
  logic [XLEN-1:0]   id_pc_nxt;
  logic [XLEN-1:0]   id_inst_nxt;
  logic              id_valid_nxt;
  logic [XLEN-1:0]   fetch_cnt_nxt;
  logic [XLEN-1:0]   redirect_aligned;
  logic [XLEN-1:0]   pc_plus4;

  assign redirect_aligned = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign pc_plus4         = pc_o + XLEN'(ILEN_B);

  // Next-state and next-register values; everything holds unless overridden.
  always_comb begin
    state_nxt      = state;
    ce_nxt         = ce_o;
    pc_nxt         = pc_o;
    pend_valid_nxt = pend_valid;
    pend_pc_nxt    = pend_pc;
    id_pc_nxt      = id_pc_o;
    id_inst_nxt    = id_inst_o;
    id_valid_nxt   = id_valid_o;
    fetch_cnt_nxt  = fetch_cnt_o;

    case (state)
      BOOT: begin
        state_nxt      = RUN;
        ce_nxt         = 1'b1;
        pc_nxt         = RESET_PC;
        pend_valid_nxt = 1'b0;
        id_pc_nxt      = pc_o;
        id_inst_nxt    = NOP_INST;
        id_valid_nxt   = 1'b0;
      end
      RUN: begin
        ce_nxt = 1'b1;
        if (redirect_valid_i && !stall_i) begin
          pc_nxt         = redirect_aligned;
          pend_valid_nxt = 1'b0;
          id_pc_nxt      = pc_o;
          id_inst_nxt    = NOP_INST;
          id_valid_nxt   = 1'b0;
        end else if (redirect_valid_i && stall_i) begin
          // Flush wins over freeze; the target is applied once the stall lifts.
          pend_valid_nxt = 1'b1;
          pend_pc_nxt    = redirect_aligned;
          id_pc_nxt      = pc_o;
          id_inst_nxt    = NOP_INST;
          id_valid_nxt   = 1'b0;
        end else if (stall_i) begin
          pc_nxt = pc_o;
        end else if (pend_valid) begin
          // Word at the current pc_o is wrong-path; drop it.
          pc_nxt         = pend_pc;
          pend_valid_nxt = 1'b0;
          id_pc_nxt      = pc_o;
          id_inst_nxt    = NOP_INST;
          id_valid_nxt   = 1'b0;
        end else begin
          pc_nxt        = pc_plus4;
          id_pc_nxt     = pc_o;
          id_inst_nxt   = inst_i;
          id_valid_nxt  = 1'b1;
          fetch_cnt_nxt = fetch_cnt_o + XLEN'(1);
        end
      end
      default: begin
        state_nxt = BOOT;
        ce_nxt    = 1'b0;
      end
    endcase
  end

  // State and pipeline registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= BOOT;
      ce_o        <= 1'b0;
      pc_o        <= RESET_PC;
      pend_valid  <= 1'b0;
      pend_pc     <= '0;
      id_pc_o     <= '0;
      id_inst_o   <= NOP_INST;
      id_valid_o  <= 1'b0;
      fetch_cnt_o <= '0;
    end else begin
      state       <= state_nxt;
      ce_o        <= ce_nxt;
      pc_o        <= pc_nxt;
      pend_valid  <= pend_valid_nxt;
      pend_pc     <= pend_pc_nxt;
      id_pc_o     <= id_pc_nxt;
      id_inst_o   <= id_inst_nxt;
      id_valid_o  <= id_valid_nxt;
      fetch_cnt_o <= fetch_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_rv32i_if_stage.sv
// Self-checking bench for rv32i_if_stage: reference model compared every
// cycle plus directed literal checks.
module tb_rv32i_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        rv;
  logic [31:0] rpc;
  logic [31:0] inst;
  logic        ce;
  logic [31:0] pc;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
  logic [31:0] cnt;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  rv32i_if_stage #(.RESET_PC(32'h0), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .stall_i(stall), .redirect_valid_i(rv),
    .redirect_pc_i(rpc), .inst_i(inst), .ce_o(ce), .pc_o(pc),
    .id_pc_o(id_pc), .id_inst_o(id_inst), .id_valid_o(id_valid),
    .fetch_cnt_o(cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h00C0_0093;
    return 32'hA500_0000 | (a & 32'h00FF_FFFF);
  endfunction

  assign inst = rom_word(pc);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: program-level view of the fetch stage.
  logic [31:0] m_pc, m_idpc, m_inst, m_cnt, m_pend_pc;
  logic        m_ce, m_valid, m_pend, m_boot;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pc = 32'h0; m_ce = 0; m_idpc = 0; m_inst = NOP; m_valid = 0;
      m_cnt = 0; m_pend = 0; m_pend_pc = 0; m_boot = 1;
    end else if (m_boot) begin
      m_boot = 0; m_ce = 1; m_inst = NOP; m_valid = 0; m_idpc = m_pc;
    end else if (rv) begin
      m_inst = NOP; m_valid = 0; m_idpc = m_pc;
      if (stall) begin
        m_pend = 1; m_pend_pc = rpc & ~32'h3;
      end else begin
        m_pend = 0; m_pc = rpc & ~32'h3;
      end
    end else if (stall) begin
      // frozen
    end else if (m_pend) begin
      m_inst = NOP; m_valid = 0; m_idpc = m_pc; m_pc = m_pend_pc; m_pend = 0;
    end else begin
      m_idpc = m_pc; m_inst = rom_word(m_pc); m_valid = 1;
      m_pc = m_pc + 32'd4; m_cnt = m_cnt + 32'd1;
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst) begin
      chk("model_ce", {31'b0, ce}, {31'b0, m_ce});
      chk("model_pc", pc, m_pc);
      chk("model_id_valid", {31'b0, id_valid}, {31'b0, m_valid});
      chk("model_id_inst", id_inst, m_inst);
      chk("model_cnt", cnt, m_cnt);
      if (m_valid) chk("model_id_pc", id_pc, m_idpc);
    end
  end

  task automatic tick(input logic s, input logic r, input logic [31:0] t);
    stall = s; rv = r; rpc = t;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_ce"}, {31'b0, ce}, 32'h0);
    chk({tag, "_id_valid"}, {31'b0, id_valid}, 32'h0);
    chk({tag, "_id_inst"}, id_inst, NOP);
    chk({tag, "_id_pc"}, id_pc, 32'h0);
    chk({tag, "_cnt"}, cnt, 32'h0);
  endtask

  initial begin
    rst = 0; stall = 0; rv = 0; rpc = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst = 1; chk_en = 1;

    // Boot edge, then first fetch.
    tick(0, 0, 0);
    chk("boot_ce", {31'b0, ce}, 32'h1);
    chk("boot_valid", {31'b0, id_valid}, 32'h0);
    chk("boot_pc", pc, 32'h0);
    tick(0, 0, 0);
    chk("first_inst", id_inst, 32'h00C0_0093);
    chk("first_id_pc", id_pc, 32'h0);
    chk("first_pc", pc, 32'h4);
    chk("first_cnt", cnt, 32'h1);

    // Sequential fetch.
    for (int i = 1; i < 5; i++) begin
      tick(0, 0, 0);
      chk("seq_id_pc", id_pc, 32'(i * 4));
      chk("seq_valid", {31'b0, id_valid}, 32'h1);
    end
    chk("seq_cnt", cnt, 32'd5);
    tick(0, 0, 0);
    chk("seq_pc24", pc, 32'd24);

    // Plain redirect with misaligned target.
    tick(0, 1, 32'h36);
    chk("redir_pc", pc, 32'h34);
    chk("redir_valid", {31'b0, id_valid}, 32'h0);
    chk("redir_inst", id_inst, NOP);
    chk("redir_id_pc", id_pc, 32'd24);
    chk("redir_cnt", cnt, 32'd6);
    tick(0, 0, 0);
    chk("redir_tgt_id_pc", id_pc, 32'h34);
    chk("redir_tgt_cnt", cnt, 32'd7);

    // Redirects during a stall; newest wins.
    tick(1, 1, 32'h40);
    chk("pstall1_pc", pc, 32'h38);
    chk("pstall1_valid", {31'b0, id_valid}, 32'h0);
    tick(1, 1, 32'h50);
    chk("pstall2_pc", pc, 32'h38);
    tick(1, 0, 0);
    chk("pstall3_pc", pc, 32'h38);
    tick(0, 0, 0);
    chk("pend_apply_pc", pc, 32'h50);
    chk("pend_apply_valid", {31'b0, id_valid}, 32'h0);
    chk("pend_apply_cnt", cnt, 32'd7);
    tick(0, 0, 0);
    chk("pend_tgt_id_pc", id_pc, 32'h50);
    chk("pend_tgt_cnt", cnt, 32'd8);

    // Async reset while a redirect is pending.
    tick(1, 1, 32'h80);
    #2 rst = 0;
    #1 chk_reset_vals("async_reset");
    @(posedge clk);
    #1;
    rst = 1;
    // Boot ignores stall/redirect.
    tick(1, 1, 32'h80);
    chk("reboot_pc", pc, 32'h0);
    chk("reboot_valid", {31'b0, id_valid}, 32'h0);
    tick(0, 0, 0);
    chk("reboot_id_pc", id_pc, 32'h0);
    chk("reboot_next_pc", pc, 32'h4);
    tick(0, 0, 0);
    tick(0, 0, 0);
    chk("pre_stall_id_pc", id_pc, 32'h8);

    // Stall only.
    for (int i = 0; i < 4; i++) begin
      tick(1, 0, 0);
      chk("stall_id_pc", id_pc, 32'h8);
      chk("stall_id_inst", id_inst, 32'hA500_0008);
      chk("stall_pc", pc, 32'd12);
      chk("stall_cnt", cnt, 32'd3);
    end
    tick(0, 0, 0);
    chk("resume_id_pc", id_pc, 32'd12);

    // PC wraps modulo 2^32.
    tick(0, 1, 32'hFFFF_FFFF);
    chk("wrap_redir_pc", pc, 32'hFFFF_FFFC);
    tick(0, 0, 0);
    chk("wrap_id_pc", id_pc, 32'hFFFF_FFFC);
    chk("wrap_pc", pc, 32'h0);
    tick(0, 0, 0);
    chk("wrap_next_id_pc", id_pc, 32'h0);

    // Mixed stall/redirect traffic checked by the model.
    for (int i = 0; i < 60; i++) begin
      tick(logic'($urandom_range(0, 2) == 0), logic'($urandom_range(0, 4) == 0),
           $urandom_range(0, 255));
    end
    tick(0, 0, 0);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
